// File: rtl/traffic_phase_ctrl.sv
// N-phase intersection light sequencer: round-robin green/yellow/all-red with flow-dependent green time.
// Optional emergency preemption is compiled in when TRAFFIC_PREEMPT_EN is defined.
module traffic_phase_ctrl #(
    parameter int NUM_PHASES   = 4,
    parameter int TICK_DIV     = 50000000,
    parameter int CNT_W        = 8,
    parameter int YELLOW_TIME  = 5,
    parameter int ALL_RED_TIME = 2,
    parameter int G_EQ         = 44,
    parameter int G_MED_HI     = 55,
    parameter int G_MED_LO     = 33,
    parameter int G_HVY_HI     = 66,
    parameter int G_HVY_LO     = 22,
    localparam int PW          = $clog2(NUM_PHASES)
) (
    input  logic                  CLK,
    input  logic                  Reset1,
    input  logic                  hold,
    input  logic [2:0]            flowspeed,
    input  logic [PW-1:0]         priority_sel,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic                  emerg_req,
    input  logic [PW-1:0]         emerg_phase,
`endif
    output logic [NUM_PHASES-1:0] red,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] green,
    output logic [PW-1:0]         phase,
    output logic [CNT_W-1:0]      remaining,
    output logic [3:0]            bcd_tens,
    output logic [3:0]            bcd_ones,
    output logic                  phase_done,
    output logic                  cycle_done
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_PHASES - 1);

    if (G_EQ >= (1 << CNT_W) || G_MED_HI >= (1 << CNT_W) || G_MED_LO >= (1 << CNT_W) ||
        G_HVY_HI >= (1 << CNT_W) || G_HVY_LO >= (1 << CNT_W) ||
        YELLOW_TIME >= (1 << CNT_W) || ALL_RED_TIME >= (1 << CNT_W)) begin : g_width_check
        $error("traffic_phase_ctrl: a state duration does not fit in CNT_W bits");
    end

    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED} state_t;

    state_t                  state, state_nxt;
    logic [PW-1:0]           phase_nxt;
    logic [CNT_W-1:0]        remaining_nxt;
    logic [DW-1:0]           div_cnt, div_nxt;
    logic [NUM_PHASES-1:0]   onehot, red_nxt, yellow_nxt, green_nxt;
    logic                    phase_done_nxt, cycle_done_nxt;
    logic                    frozen, tick;
    logic [PW-1:0]           rr_next;
    int unsigned             rem_val;
`ifdef TRAFFIC_PREEMPT_EN
    logic                    pend, pend_nxt;
    logic [PW-1:0]           target, target_nxt;
`endif

    // Green time for phase p, decided only at the moment GREEN(p) is entered.
    function automatic logic [CNT_W-1:0] green_time(input logic [PW-1:0] p,
                                                    input logic [2:0]    fs,
                                                    input logic [PW-1:0] prio);
        logic hi;
        hi = (int'(prio) < NUM_PHASES) && (p == prio);
        case (fs)
            3'b001:         return hi ? CNT_W'(G_MED_HI) : CNT_W'(G_MED_LO);
            3'b011, 3'b111: return hi ? CNT_W'(G_HVY_HI) : CNT_W'(G_HVY_LO);
            default:        return CNT_W'(G_EQ);
        endcase
    endfunction

`ifdef TRAFFIC_PREEMPT_EN
    assign frozen = hold && !emerg_req;
`else
    assign frozen = hold;
`endif
    assign tick    = !frozen && (div_cnt == DW'(TICK_DIV - 1));
    assign rr_next = (phase == LAST_PHASE) ? '0 : phase + 1'b1;

    always_ff @(posedge CLK or negedge Reset1) begin
        if (!Reset1) begin
            state      <= S_ALLRED;
            phase      <= LAST_PHASE;
            remaining  <= CNT_W'(ALL_RED_TIME);
            div_cnt    <= '0;
            red        <= '1;
            yellow     <= '0;
            green      <= '0;
            phase_done <= 1'b0;
            cycle_done <= 1'b0;
`ifdef TRAFFIC_PREEMPT_EN
            pend       <= 1'b0;
            target     <= '0;
`endif
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            remaining  <= remaining_nxt;
            div_cnt    <= div_nxt;
            red        <= red_nxt;
            yellow     <= yellow_nxt;
            green      <= green_nxt;
            phase_done <= phase_done_nxt;
            cycle_done <= cycle_done_nxt;
`ifdef TRAFFIC_PREEMPT_EN
            pend       <= pend_nxt;
            target     <= target_nxt;
`endif
        end
    end

    // A tick on the last second of a state advances it; lamps are derived from the next state.
    always_comb begin
        state_nxt      = state;
        phase_nxt      = phase;
        remaining_nxt  = remaining;
        div_nxt        = div_cnt;
        phase_done_nxt = 1'b0;
        cycle_done_nxt = 1'b0;
`ifdef TRAFFIC_PREEMPT_EN
        pend_nxt       = pend;
        target_nxt     = target;
        if (emerg_req) begin
            target_nxt = emerg_phase;
            pend_nxt   = !(state == S_GREEN && phase == emerg_phase);
        end
`endif
        if (!frozen)
            div_nxt = tick ? '0 : div_cnt + 1'b1;
`ifdef TRAFFIC_PREEMPT_EN
        if (emerg_req && state == S_GREEN) begin
            if (phase != emerg_phase) begin
                state_nxt     = S_YELLOW;
                remaining_nxt = CNT_W'(YELLOW_TIME);
            end
        end else
`endif
        if (tick) begin
            if (remaining == CNT_W'(1)) begin
                case (state)
                    S_GREEN: begin
                        state_nxt     = S_YELLOW;
                        remaining_nxt = CNT_W'(YELLOW_TIME);
                    end
                    S_YELLOW: begin
                        state_nxt     = S_ALLRED;
                        remaining_nxt = CNT_W'(ALL_RED_TIME);
                    end
                    default: begin
                        state_nxt      = S_GREEN;
                        phase_nxt      = rr_next;
`ifdef TRAFFIC_PREEMPT_EN
                        if (pend_nxt) begin
                            phase_nxt = target_nxt;
                            pend_nxt  = 1'b0;
                        end
`endif
                        remaining_nxt  = green_time(phase_nxt, flowspeed, priority_sel);
                        phase_done_nxt = 1'b1;
                        cycle_done_nxt = (phase == LAST_PHASE);
                    end
                endcase
            end else begin
                remaining_nxt = remaining - 1'b1;
            end
        end
        onehot     = NUM_PHASES'(1) << phase_nxt;
        green_nxt  = (state_nxt == S_GREEN)  ? onehot : '0;
        yellow_nxt = (state_nxt == S_YELLOW) ? onehot : '0;
        red_nxt    = ~(green_nxt | yellow_nxt);
    end

    always_comb begin
        rem_val = 32'(remaining);
        if (rem_val > 99) begin
            bcd_tens = 4'd9;
            bcd_ones = 4'd9;
        end else begin
            bcd_tens = 4'(rem_val / 10);
            bcd_ones = 4'(rem_val % 10);
        end
    end

endmodule
